// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM state types and frame arithmetic.
// Used by the transceiver top and by anything that needs to size a frame.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  // Clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: oversampled receiver with glitch rejection, valid/ready
// transmitter and an echo path that retransmits clean received words.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK50M,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic                 TX,
  input  logic                 ECHO,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  output logic                 tx_busy
);

  localparam int            DIV       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_HALF   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit            ODD       = (PARITY == PAR_ODD);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (CLK50M),
    .rst_n (RST_N),
    .tick  (tick)
  );

  // ---------------------------------------------------------------- receiver
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [TW-1:0]        rx_tick_q, rx_tick_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;

  // Idle-high synchroniser so reset release never looks like a start bit.
  always_ff @(posedge CLK50M or negedge RST_N) begin
    // NOTE: non-blocking assignments let rx_sync_q see the old rx_meta_q, giving two real stages.
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_valid_d   = 1'b0;
    rx_perr_d    = 1'b0;
    rx_ferr_d    = 1'b0;
    if (tick) begin
      case (rx_state_q)
        RX_IDLE: if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
        end
        RX_START: if (rx_tick_q == OS_HALF) begin
          rx_tick_d    = '0;
          rx_bit_d     = '0;
          rx_par_bad_d = 1'b0;
          rx_state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_tick_d = rx_tick_q + 1'b1;
        end
        default: if (rx_tick_q != OS_LAST) begin
          rx_tick_d = rx_tick_q + 1'b1;
        end else begin
          rx_tick_d = '0;
          case (rx_state_q)
            RX_DATA: begin
              rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_d   = rx_bit_q + 1'b1;
              if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
            end
            RX_PAR: begin
              rx_par_bad_d = rx_sync_q ^ (^rx_shift_q) ^ ODD;
              rx_state_d   = RX_STOP;
            end
            default: begin
              // First stop bit only; idle again mid-stop so a following start edge is caught.
              rx_state_d = RX_IDLE;
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              rx_perr_d  = rx_par_bad_q;
              rx_ferr_d  = !rx_sync_q;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_par_bad_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

  // ------------------------------------------------------------- transmitter
  tx_state_e            tx_state_q, tx_state_d;
  logic [TW-1:0]        tx_tick_q, tx_tick_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_out_q, tx_out_d;
  logic                 echo_load, tx_load;
  logic [DATA_BITS-1:0] tx_load_data;

  assign echo_load    = rx_valid_q & ECHO & !rx_perr_q & !rx_ferr_q;
  assign tx_ready     = (tx_state_q == TX_IDLE) & !ECHO & RST_N;
  assign tx_load      = (tx_valid & tx_ready) | (echo_load & (tx_state_q == TX_IDLE));
  assign tx_load_data = echo_load ? rx_data_q : tx_data;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    if (tx_state_q == TX_IDLE) begin
      // Start bit goes out on the next clock, not the next tick.
      if (tx_load) begin
        tx_state_d = TX_START;
        tx_tick_d  = '0;
        tx_shift_d = tx_load_data;
        tx_par_d   = (^tx_load_data) ^ ODD;
        tx_out_d   = 1'b0;
      end
    end else if (tick) begin
      if (tx_tick_q != OS_LAST) begin
        tx_tick_d = tx_tick_q + 1'b1;
      end else begin
        tx_tick_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
            tx_out_d   = tx_shift_q[0];
          end
          TX_DATA: if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
            tx_out_d   = HAS_PAR ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_out_d   = tx_shift_q[1];
          end
          TX_PAR: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
            tx_out_d   = 1'b1;
          end
          default: if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
                   else                       tx_bit_d   = tx_bit_q + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign TX            = tx_out_q;
  assign tx_busy       = (tx_state_q != TX_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = echo_load & (tx_state_q != TX_IDLE);
  assign rx_busy       = (rx_state_q != RX_IDLE) | rx_valid_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr: an 8N1 instance (TX, RX, echo, reset) and an
// 8E1 instance (receive parity), both at 16 clocks per bit.
module tb_uart_xcvr;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rx_exp_t;

  logic clk, rst_n;
  logic rx, rx_e, echo, tx_valid;
  logic [7:0] tx_data;
  logic tx, tx_ready, rx_valid, rx_perr, rx_ferr, rx_ovr, rx_busy, tx_busy;
  logic [7:0] rx_data;
  logic e_tx, e_tx_ready, e_rx_valid, e_rx_perr, e_rx_ferr, e_rx_ovr, e_rx_busy, e_tx_busy;
  logic [7:0] e_rx_data;

  rx_exp_t    rx_q[$];
  rx_exp_t    rxe_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;

  uart_xcvr #(.CLK_HZ(16), .BAUD(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .CLK50M(clk), .RST_N(rst_n), .RX(rx), .TX(tx), .ECHO(echo),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_perr), .rx_frame_err(rx_ferr),
    .rx_overrun(rx_ovr), .rx_busy(rx_busy), .tx_busy(tx_busy)
  );

  uart_xcvr #(.CLK_HZ(16), .BAUD(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_e (
    .CLK50M(clk), .RST_N(rst_n), .RX(rx_e), .TX(e_tx), .ECHO(1'b0),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(e_tx_ready),
    .rx_data(e_rx_data), .rx_valid(e_rx_valid), .rx_parity_err(e_rx_perr), .rx_frame_err(e_rx_ferr),
    .rx_overrun(e_rx_ovr), .rx_busy(e_rx_busy), .tx_busy(e_tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rx_exp_t mk_exp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    rx_exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
    return e;
  endfunction

  // Line image of one frame, bit 0 sent first.
  function automatic logic [11:0] frame8(input logic [7:0] d, input logic with_par, input logic p, input logic stop);
    if (with_par) return {1'b0, stop, p, d, 1'b0};
    return {2'b00, stop, d, 1'b0};
  endfunction

  task automatic drive_rx(input logic sel, input logic [11:0] bits, input int n, input int last_len);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (sel) rx_e = bits[i];
      else     rx   = bits[i];
      repeat ((i == n - 1) ? last_len : 16) @(posedge clk);
      #1;
    end
    rx   = 1'b1;
    rx_e = 1'b1;
  endtask

  task automatic send_host(input logic [7:0] d, input bit measure);
    int w;
    int cnt;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) begin
      check("tx_ready_wait_timeout", 32'(tx_ready), 1);
      return;
    end
    tx_q.push_back(d);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (measure) begin
      cnt = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (tx_ready) break;
        cnt++;
      end
      check("tx_ready_low_cycles", cnt, 160);
    end
  endtask

  // Receive scoreboard, 8N1 instance.
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid) begin
        if (rx_q.size() == 0) check("rx_unexpected_valid", 32'(rx_valid), 0);
        else begin
          e = rx_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_parity_err", 32'(rx_perr), 32'(e.perr));
          check("rx_frame_err", 32'(rx_ferr), 32'(e.ferr));
          check("rx_overrun", 32'(rx_ovr), 32'(e.ovr));
        end
      end else if (rst_n && rx_ovr) begin
        check("rx_overrun_without_valid", 32'(rx_ovr), 0);
      end
    end
  end

  // Receive scoreboard, 8E1 instance.
  initial begin : rxe_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && e_rx_valid) begin
        if (rxe_q.size() == 0) check("rxe_unexpected_valid", 32'(e_rx_valid), 0);
        else begin
          e = rxe_q.pop_front();
          check("rxe_data", 32'(e_rx_data), 32'(e.data));
          check("rxe_parity_err", 32'(e_rx_perr), 32'(e.perr));
          check("rxe_frame_err", 32'(e_rx_ferr), 32'(e.ferr));
        end
      end
    end
  end

  // Transmit monitor: every cycle of a frame must match the expected bit.
  initial begin : tx_mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic [7:0] dec;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && !tx) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", 32'(tx), 1);
          wait (tx || !rst_n);
        end else begin
          exp_b   = tx_q.pop_front();
          bits    = {1'b1, exp_b, 1'b0};
          bad     = 0;
          aborted = 0;
          dec     = '0;
          for (int i = 0; i < 160; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1;
              break;
            end
            if (tx !== bits[i/16]) bad++;
            if (i >= 24 && i < 152 && (i % 16) == 8) dec[i/16-1] = tx;
          end
          if (!aborted) begin
            check("tx_wave_bad_cycles", bad, 0);
            check("tx_byte", 32'(dec), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; rx = 1'b1; rx_e = 1'b1; echo = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 1);
    check("reset_tx_ready", 32'(tx_ready), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_busy", 32'(rx_busy), 0);
    check("reset_tx_busy", 32'(tx_busy), 0);
    check("reset_rx_err", 32'({rx_perr, rx_ferr, rx_ovr}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("tx_ready_after_reset", 32'(tx_ready), 1);

    // Host send 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    send_host(8'hA5, 1);

    // Clean 8N1 receive.
    rx_q.push_back(mk_exp(8'h3C, 1'b0, 1'b0, 1'b0));
    fork
      drive_rx(1'b0, frame8(8'h3C, 1'b0, 1'b0, 1'b1), 10, 16);
      begin
        repeat (80) @(negedge clk);
        check("rx_busy_mid_frame", 32'(rx_busy), 1);
      end
    join
    repeat (20) @(posedge clk);

    // 8E1: 0x07 has three ones, so even parity bit must be 1.
    rxe_q.push_back(mk_exp(8'h07, 1'b1, 1'b0, 1'b0));
    drive_rx(1'b1, frame8(8'h07, 1'b1, 1'b0, 1'b1), 11, 16);
    rxe_q.push_back(mk_exp(8'h07, 1'b0, 1'b0, 1'b0));
    drive_rx(1'b1, frame8(8'h07, 1'b1, 1'b1, 1'b1), 11, 16);
    repeat (20) @(posedge clk);

    // Start glitch of 4 cycles: receiver arms, then drops back without output.
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    check("rx_busy_during_glitch", 32'(rx_busy), 1);
    repeat (30) @(negedge clk);
    check("rx_busy_after_glitch", 32'(rx_busy), 0);

    // Stop bit held low long enough to be sampled.
    rx_q.push_back(mk_exp(8'h55, 1'b0, 1'b1, 1'b0));
    drive_rx(1'b0, frame8(8'h55, 1'b0, 1'b0, 1'b0), 10, 10);
    repeat (40) @(posedge clk);

    // Echo: first word retransmitted, second arrives while TX busy and is dropped.
    echo = 1'b1;
    @(negedge clk);
    check("tx_ready_in_echo", 32'(tx_ready), 0);
    rx_q.push_back(mk_exp(8'h11, 1'b0, 1'b0, 1'b0));
    rx_q.push_back(mk_exp(8'h22, 1'b0, 1'b0, 1'b1));
    tx_q.push_back(8'h11);
    drive_rx(1'b0, frame8(8'h11, 1'b0, 1'b0, 1'b1), 10, 12);
    drive_rx(1'b0, frame8(8'h22, 1'b0, 1'b0, 1'b1), 10, 16);
    repeat (60) @(posedge clk);
    #1 echo = 1'b0;

    // Reset during the first data bit (0 for 0x5A) forces the line high at once.
    send_host(8'h5A, 0);
    repeat (20) @(posedge clk);
    #2;
    check("tx_low_before_reset", 32'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("tx_high_in_reset", 32'(tx), 1);
    check("tx_busy_in_reset", 32'(tx_busy), 0);
    check("tx_ready_in_reset", 32'(tx_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("tx_ready_after_mid_reset", 32'(tx_ready), 1);
    send_host(8'hC3, 1);
    repeat (20) @(posedge clk);

    check("rx_queue_drained", rx_q.size(), 0);
    check("rxe_queue_drained", rxe_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: 16x-oversampled receiver with start-glitch rejection, configurable frame (data bits, parity, stop bits), valid/ready transmit interface and a hardware echo mode. It replaces the fixed 8N1 receive-then-send path on the board top and sits directly between the `CLK50M` pin and the RX/TX pads. Status outputs drive the board LEDs.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `BAUD`, 115200: line rate.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 8.
- `DATA_BITS`, 8: 5..9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `CLK50M`  in  1  clock; all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `RX`  in  1  serial input, asynchronous to `CLK50M`.
- `TX`  out  1  serial output; idle high.
- `ECHO`  in  1  1 = received good bytes retransmitted; host TX path disabled.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  host request.
- `tx_ready`  out  1  transmitter accepts `tx_data` this cycle.
- `rx_data`  out  DATA_BITS  last received word; held until next frame.
- `rx_valid`  out  1  one-cycle pulse per completed frame.
- `rx_parity_err`, `rx_frame_err`  out  1  qualify `rx_valid`; valid only in the pulse cycle.
- `rx_overrun`  out  1  one-cycle pulse: echo byte dropped because TX busy.
- `rx_busy`, `tx_busy`  out  1  LED status.

## Operation
- Tick: `DIV = max(1, CLK_HZ / (BAUD*OVERSAMPLE))`, integer floor; a one-cycle `tick` every DIV clocks, free-running from reset.
- RX: 2-flop synchroniser, both stages reset to 1. States RX_IDLE → RX_START → RX_DATA → RX_PAR (skipped if PARITY=0) → RX_STOP → RX_IDLE.
  - RX_IDLE: synchronised `RX`=0 on a tick → RX_START, tick counter cleared.
  - RX_START: at tick OVERSAMPLE/2-1 resample; 1 → glitch, back to RX_IDLE with no output; 0 → RX_DATA.
  - Each subsequent bit sampled once, OVERSAMPLE ticks after the previous sample (mid-bit). Data LSB first.
  - Parity computed over DATA_BITS; mismatch sets `rx_parity_err`.
  - Only the first stop bit is checked; 0 sets `rx_frame_err`. At that sample: update `rx_data`, pulse `rx_valid`, return to RX_IDLE (re-armed mid-stop for back-to-back frames).
- TX: states TX_IDLE → TX_START → TX_DATA → TX_PAR (if enabled) → TX_STOP → TX_IDLE; each bit lasts exactly OVERSAMPLE ticks; STOP lasts STOP_BITS bits.
  - `tx_ready` = (state TX_IDLE) & !ECHO. Transfer on `tx_valid & tx_ready`; data latched internally.
- ECHO=1: on `rx_valid` with both error flags 0, if TX_IDLE load `rx_data` into TX; else pulse `rx_overrun` (same cycle as `rx_valid`), byte dropped. Errored frames never echoed.
- Changing `ECHO` mid-frame does not abort a frame in flight.

## Timing
- Reset (async assert, sync to `CLK50M` by caller on release): `TX`=1, `tx_ready`=0 while asserted then 1 (if ECHO=0) first cycle after release, `rx_data`=0, all pulses/flags/busy=0, tick counter 0, both FSMs idle. Reset mid-frame aborts immediately; `TX` high within the reset-assert event.
- TX: `TX` goes low in the cycle after the handshake cycle (not tick-aligned); total frame = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)×OVERSAMPLE ticks; `tx_ready` high again the cycle after the last stop tick.
- RX latency: `rx_valid` at mid-stop sample, i.e. ≈ (frame length − STOP_BITS + 0.5) bit times after the falling edge plus 2 synchroniser cycles.
- `rx_busy` high from RX_START to the `rx_valid` cycle inclusive; `tx_busy` = !TX_IDLE.

## Structure
- Package `uart_pkg`: parity encodings (PAR_NONE/EVEN/ODD), RX and TX state enums, function computing DIV and frame bit count.
- Sub-module `uart_baud_gen` (divider → `tick`); RX and TX FSMs stay in `uart_xcvr`.

## Test plan
Use CLK_HZ=16, BAUD=1, OVERSAMPLE=16 (DIV=1, 16 cycles/bit) unless stated.
- 8N1, host sends 0xA5 → `TX` bits 0,1,0,1,0,0,1,0,1,1 each 16 cycles; `tx_ready` low 160 cycles.
- 8N1, drive 0x3C frame on `RX` → one `rx_valid` pulse, `rx_data`=0x3C, both error flags 0.
- 8E1, drive 0x07 with parity bit 0 → `rx_valid`, `rx_parity_err`=1; with parity 1 → error 0.
- `RX` low for 4 cycles then high → no `rx_valid`, FSM back to idle; stop bit driven 0 → `rx_frame_err`=1.
- ECHO=1, two back-to-back frames 0x11, 0x22 → first echoed on `TX`, second produces `rx_overrun` pulse and is dropped.
- Assert `RST_N`=0 mid-TX data bit → `TX`=1 immediately; after release, `tx_ready`=1 and next send is a full clean frame.
